// File: rtl/fft_pkg.sv
// Shared widths, pairing phase encoding and the fixed-point round/saturate helpers
// used by the radix-2 butterfly datapath.
package fft_pkg;

  localparam int N       = 16;
  localparam int SIZE    = 4;
  localparam int DW      = 16;
  localparam int TW      = 16;
  localparam int ANGLE_W = 10;

  typedef enum logic {
    PHASE_TOP = 1'b0,
    PHASE_BOT = 1'b1
  } phase_t;

  // Arithmetic shift right by sh (sh >= 1) with round-half-up.
  function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int sh);
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  // Clamp to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/fft_butterfly_stage_if.sv
// Butterfly stage bus: read strobe/address/angle in, RAM and twiddle ROM data in,
// stage write port and status out. slave = butterfly, master = address gen + memories.
interface fft_butterfly_stage_if #(
  parameter int SIZE = fft_pkg::SIZE,
  parameter int DW   = fft_pkg::DW,
  parameter int TW   = fft_pkg::TW
);
  import fft_pkg::*;

  logic                    en_rd_i;
  logic [SIZE-1:0]         rd_ptr_i;
  logic [ANGLE_W:0]        rd_angle_i;
  logic signed [DW-1:0]    rd_re_i;
  logic signed [DW-1:0]    rd_im_i;
  logic [ANGLE_W-1:0]      tw_addr_o;
  logic signed [TW-1:0]    tw_re_i;
  logic signed [TW-1:0]    tw_im_i;
  logic                    wr_en_o;
  logic [SIZE-1:0]         wr_addr_o;
  logic signed [DW-1:0]    wr_re_o;
  logic signed [DW-1:0]    wr_im_o;
  logic                    stage_done_o;
  logic                    busy_o;

  modport slave (
    input  en_rd_i, rd_ptr_i, rd_angle_i, rd_re_i, rd_im_i, tw_re_i, tw_im_i,
    output tw_addr_o, wr_en_o, wr_addr_o, wr_re_o, wr_im_o, stage_done_o, busy_o
  );

  modport master (
    output en_rd_i, rd_ptr_i, rd_angle_i, rd_re_i, rd_im_i, tw_re_i, tw_im_i,
    input  tw_addr_o, wr_en_o, wr_addr_o, wr_re_o, wr_im_o, stage_done_o, busy_o
  );

endinterface

// File: rtl/fft_cmult.sv
// P = B*W with W in Q2.(TW-2): four multipliers, rounded and saturated to DW.
// One register stage; no backpressure, accepts a new operand pair every cycle.
module fft_cmult #(
  parameter int DW = fft_pkg::DW,
  parameter int TW = fft_pkg::TW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic signed [DW-1:0] p_re,
  output logic signed [DW-1:0] p_im
);
  import fft_pkg::*;

  logic signed [DW+TW-1:0] rr, ii, ri, ir;
  logic signed [DW+TW:0]   acc_re, acc_im;

  assign rr = b_re * w_re;
  assign ii = b_im * w_im;
  assign ri = b_re * w_im;
  assign ir = b_im * w_re;

  assign acc_re = (DW+TW+1)'(rr) - (DW+TW+1)'(ii);
  assign acc_im = (DW+TW+1)'(ri) + (DW+TW+1)'(ir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re <= '0;
      p_im <= '0;
    end else begin
      p_re <= DW'(sat(rnd_shr(64'(acc_re), TW - 2), DW));
      p_im <= DW'(sat(rnd_shr(64'(acc_im), TW - 2), DW));
    end
  end

endmodule

// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly: X=(A+BW)/2 to top addr 3 cycles after the bottom read, Y one cycle later.
// No stall path: pairs at a 2-cycle cadence stream at one write per cycle.
module fft_butterfly_stage #(
  parameter int N    = fft_pkg::N,
  parameter int SIZE = fft_pkg::SIZE,
  parameter int DW   = fft_pkg::DW,
  parameter int TW   = fft_pkg::TW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_butterfly_stage_if.slave bus
);
  import fft_pkg::*;

  localparam logic [SIZE-1:0] LAST_PAIR = SIZE'(N / 2 - 1);

  phase_t               phase;
  logic                 start_pair, close_pair;
  logic                 vld1, vld2, vld3, pend_bot, last_wr;
  logic [SIZE-1:0]      top0, top1, bot1, top2, bot2, top3, bot3, bot_hold, pair_cnt;
  logic signed [DW-1:0] a1_re, a1_im, a2_re, a2_im, a3_re, a3_im, b2_re, b2_im;
  logic signed [TW-1:0] w1_re, w1_im, w2_re, w2_im;
  logic signed [DW-1:0] p_re, p_im, x_re, x_im, y_re, y_im, y_hold_re, y_hold_im;
  logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im;
  logic                 unused_angle_msb;

  assign unused_angle_msb = bus.rd_angle_i[ANGLE_W];
  assign bus.tw_addr_o    = bus.rd_angle_i[ANGLE_W-1:0];

  // A strobe on a BOT cycle always follows a TOP strobe, so it completes a pair;
  // a TOP strobe with no successor never reaches vld1 and is silently dropped.
  assign start_pair = bus.en_rd_i && (phase == PHASE_TOP);
  assign close_pair = bus.en_rd_i && (phase == PHASE_BOT);

  assign bus.busy_o = vld1 | vld2 | vld3 | pend_bot | bus.wr_en_o | (pair_cnt != '0);

  fft_cmult #(.DW(DW), .TW(TW)) u_cmult (
    .clk  (clk),
    .rst_n(rst_n),
    .b_re (b2_re),
    .b_im (b2_im),
    .w_re (w2_re),
    .w_im (w2_im),
    .p_re (p_re),
    .p_im (p_im)
  );

  always_comb begin
    sum_re = (DW+1)'(a3_re) + (DW+1)'(p_re);
    sum_im = (DW+1)'(a3_im) + (DW+1)'(p_im);
    dif_re = (DW+1)'(a3_re) - (DW+1)'(p_re);
    dif_im = (DW+1)'(a3_im) - (DW+1)'(p_im);
    x_re   = DW'(rnd_shr(64'(sum_re), 1));
    x_im   = DW'(rnd_shr(64'(sum_im), 1));
    y_re   = DW'(rnd_shr(64'(dif_re), 1));
    y_im   = DW'(rnd_shr(64'(dif_im), 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase            <= PHASE_TOP;
      top0             <= '0;
      vld1             <= 1'b0;
      vld2             <= 1'b0;
      vld3             <= 1'b0;
      {top1, bot1, top2, bot2, top3, bot3, bot_hold} <= '0;
      {a1_re, a1_im, a2_re, a2_im, a3_re, a3_im, b2_re, b2_im} <= '0;
      {w1_re, w1_im, w2_re, w2_im} <= '0;
      y_hold_re        <= '0;
      y_hold_im        <= '0;
      pend_bot         <= 1'b0;
      last_wr          <= 1'b0;
      pair_cnt         <= '0;
      bus.wr_en_o      <= 1'b0;
      bus.wr_addr_o    <= '0;
      bus.wr_re_o      <= '0;
      bus.wr_im_o      <= '0;
      bus.stage_done_o <= 1'b0;
    end else begin
      phase <= start_pair ? PHASE_BOT : PHASE_TOP;
      if (start_pair) top0 <= bus.rd_ptr_i;

      // RAM/ROM data for the top address arrives with the bottom strobe.
      vld1 <= close_pair;
      if (close_pair) begin
        a1_re <= bus.rd_re_i;
        a1_im <= bus.rd_im_i;
        w1_re <= bus.tw_re_i;
        w1_im <= bus.tw_im_i;
        top1  <= top0;
        bot1  <= bus.rd_ptr_i;
      end

      vld2 <= vld1;
      if (vld1) begin
        b2_re <= bus.rd_re_i;
        b2_im <= bus.rd_im_i;
        a2_re <= a1_re;
        a2_im <= a1_im;
        w2_re <= w1_re;
        w2_im <= w1_im;
        top2  <= top1;
        bot2  <= bot1;
      end

      vld3 <= vld2;
      if (vld2) begin
        a3_re <= a2_re;
        a3_im <= a2_im;
        top3  <= top2;
        bot3  <= bot2;
      end

      last_wr          <= 1'b0;
      bus.stage_done_o <= last_wr;

      // vld3 pulses at most every other cycle, so it never collides with pend_bot.
      if (vld3) begin
        bus.wr_en_o   <= 1'b1;
        bus.wr_addr_o <= top3;
        bus.wr_re_o   <= x_re;
        bus.wr_im_o   <= x_im;
        y_hold_re     <= y_re;
        y_hold_im     <= y_im;
        bot_hold      <= bot3;
        pend_bot      <= 1'b1;
      end else if (pend_bot) begin
        bus.wr_en_o   <= 1'b1;
        bus.wr_addr_o <= bot_hold;
        bus.wr_re_o   <= y_hold_re;
        bus.wr_im_o   <= y_hold_im;
        pend_bot      <= 1'b0;
        if (pair_cnt == LAST_PAIR) begin
          pair_cnt <= '0;
          last_wr  <= 1'b1;
        end else begin
          pair_cnt <= pair_cnt + 1'b1;
        end
      end else begin
        bus.wr_en_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed bench for fft_butterfly_stage: memory/ROM models with 1-cycle latency,
// write-port monitor with edge stamps, hand-computed expected butterfly outputs.
module tb_fft_butterfly_stage;
  import fft_pkg::*;

  typedef struct {
    int addr;
    int re;
    int im;
    int stamp;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fft_butterfly_stage_if #(.SIZE(4), .DW(16), .TW(16)) bus ();

  fft_butterfly_stage #(.N(16), .SIZE(4), .DW(16), .TW(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic signed [15:0] mem_re [16];
  logic signed [15:0] mem_im [16];
  int last_ptr = 0;
  int bot_edge = 0;
  int edge_cnt = 0;
  wr_t wq[$];
  int  done_q[$];

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (bus.wr_en_o)
      wq.push_back('{int'(bus.wr_addr_o), int'(bus.wr_re_o), int'(bus.wr_im_o), edge_cnt});
    if (bus.stage_done_o) done_q.push_back(edge_cnt);
  end

  function automatic int tw_re_f(input int a);
    case (a)
      128:     return 11585;
      256:     return 0;
      default: return 16384;
    endcase
  endfunction

  function automatic int tw_im_f(input int a);
    case (a)
      128:     return -11585;
      256:     return -16384;
      default: return 0;
    endcase
  endfunction

  // One cycle of stimulus; RAM/ROM return data for last cycle's address.
  task automatic drive(input bit en, input int ptr, input int ang);
    @(negedge clk);
    bus.rd_re_i    = mem_re[last_ptr];
    bus.rd_im_i    = mem_im[last_ptr];
    bus.tw_re_i    = 16'(tw_re_f(int'(bus.tw_addr_o)));
    bus.tw_im_i    = 16'(tw_im_f(int'(bus.tw_addr_o)));
    bus.en_rd_i    = en;
    bus.rd_ptr_i   = 4'(ptr);
    bus.rd_angle_i = 11'(ang);
    last_ptr       = ptr & 15;
  endtask

  task automatic pair(input int top, input int bot, input int ang);
    drive(1'b1, top, ang);
    drive(1'b1, bot, 0);
    bot_edge = edge_cnt + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic set_mem(input int a, input int re, input int im);
    mem_re[a] = 16'(re);
    mem_im[a] = 16'(im);
  endtask

  task automatic expect_pair(input string tag, input int top, input int bot,
                             input int xr, input int xi, input int yr, input int yi, input int b);
    check($sformatf("%s nwr", tag), wq.size(), 2);
    check($sformatf("%s top_addr", tag), wq.size() > 0 ? wq[0].addr : -1, top);
    check($sformatf("%s x_re", tag), wq.size() > 0 ? wq[0].re : 99999, xr);
    check($sformatf("%s x_im", tag), wq.size() > 0 ? wq[0].im : 99999, xi);
    check($sformatf("%s x_time", tag), wq.size() > 0 ? wq[0].stamp : -1, b + 3);
    check($sformatf("%s bot_addr", tag), wq.size() > 1 ? wq[1].addr : -1, bot);
    check($sformatf("%s y_re", tag), wq.size() > 1 ? wq[1].re : 99999, yr);
    check($sformatf("%s y_im", tag), wq.size() > 1 ? wq[1].im : 99999, yi);
    check($sformatf("%s y_time", tag), wq.size() > 1 ? wq[1].stamp : -1, b + 4);
    wq.delete();
  endtask

  initial begin
    int b0;
    int bl;
    bus.en_rd_i = 1'b0; bus.rd_ptr_i = '0; bus.rd_angle_i = '0;
    bus.rd_re_i = '0; bus.rd_im_i = '0; bus.tw_re_i = '0; bus.tw_im_i = '0;
    for (int i = 0; i < 16; i++) set_mem(i, 0, 0);
    #2 rst_n = 1'b0;
    idle(2);
    #1;
    check("rst wr_en", int'(bus.wr_en_o), 0);
    check("rst done", int'(bus.stage_done_o), 0);
    check("rst busy", int'(bus.busy_o), 0);
    check("rst wr_addr", int'(bus.wr_addr_o), 0);
    check("rst wr_re", int'(bus.wr_re_o), 0);
    @(negedge clk) rst_n = 1'b1;

    set_mem(0, 1000, 0); set_mem(8, 200, 0);
    pair(0, 8, 0); b0 = bot_edge; idle(8);
    expect_pair("unity", 0, 8, 600, 0, 400, 0, b0);
    check("busy cnt1", int'(bus.busy_o), 1);

    set_mem(1, 0, 0); set_mem(9, 100, 0);
    drive(1'b1, 1, 11'h400 | 256);
    #1 check("tw_addr", int'(bus.tw_addr_o), 256);
    drive(1'b1, 9, 0); b0 = edge_cnt + 1; idle(8);
    expect_pair("minus_j", 1, 9, 0, -50, 0, 50, b0);

    set_mem(2, 0, 0); set_mem(10, -32768, -32768);
    pair(2, 10, 128); b0 = bot_edge; idle(8);
    expect_pair("psat", 2, 10, -16384, 0, 16384, 0, b0);

    set_mem(3, 32767, 0); set_mem(11, 32767, 0);
    pair(3, 11, 0); b0 = bot_edge; idle(8);
    expect_pair("max", 3, 11, 32767, 0, 0, 0, b0);

    set_mem(4, -32768, 0); set_mem(12, -32768, 0);
    pair(4, 12, 0); b0 = bot_edge; idle(8);
    expect_pair("min", 4, 12, -32768, 0, 0, 0, b0);

    set_mem(5, 300, 0); set_mem(13, 100, 0); set_mem(6, 5000, 5000);
    drive(1'b1, 6, 0); drive(1'b0, 0, 0);
    pair(5, 13, 0); b0 = bot_edge; idle(8);
    expect_pair("orphan", 5, 13, 200, 0, 100, 0, b0);
    check("no early done", done_q.size(), 0);

    set_mem(7, 900, 0); set_mem(15, 100, 0);
    pair(7, 15, 0); drive(1'b0, 0, 0);
    #1 check("busy pre-rst", int'(bus.busy_o), 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst wr_en", int'(bus.wr_en_o), 0);
    check("midrst busy", int'(bus.busy_o), 0);
    check("midrst wr_addr", int'(bus.wr_addr_o), 0);
    check("midrst wr_re", int'(bus.wr_re_o), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(8);
    check("midrst nwr", wq.size(), 0);
    check("midrst done", done_q.size(), 0);
    wq.delete();

    for (int i = 0; i < 8; i++) begin
      set_mem(i, 64 * i, -32 * i);
      set_mem(i + 8, 16 * i, 8 * i);
    end
    b0 = 0;
    for (int i = 0; i < 8; i++) begin
      pair(i, i + 8, 0);
      if (i == 0) b0 = bot_edge;
    end
    bl = bot_edge;
    idle(10);
    check("stage nwr", wq.size(), 16);
    for (int k = 0; k < 16; k++) begin
      int p;
      p = k / 2;
      if (k < wq.size()) begin
        check($sformatf("stage%0d addr", k), wq[k].addr, (k % 2 == 0) ? p : p + 8);
        check($sformatf("stage%0d re", k), wq[k].re, (k % 2 == 0) ? 40 * p : 24 * p);
        check($sformatf("stage%0d im", k), wq[k].im, (k % 2 == 0) ? -12 * p : -20 * p);
        check($sformatf("stage%0d time", k), wq[k].stamp, b0 + 3 + k);
      end
    end
    check("done count", done_q.size(), 1);
    check("done time", done_q.size() > 0 ? done_q[0] : -1, bl + 5);
    check("busy end", int'(bus.busy_o), 0);
    check("done end", int'(bus.stage_done_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
